// File: rtl/tpu_loader.sv
// tpu_loader: streams host elements into the weight SRAM, then the data SRAM,
// kicks the TPU core and waits for it to finish.
//
// Ports
//   clk, srstn            clock; synchronous active-high reset
//   load_start            single-cycle job request (honoured only when idle)
//   in_valid/in_ready/in_data
//                         host element stream, DATA_WIDTH bits per element
//   sram_wen_w/waddr_w/wdata_w
//                         weight SRAM write port (registered)
//   sram_wen_d/waddr_d/wdata_d
//                         data SRAM write port (registered)
//   tpu_start, tpu_done   start pulse to / completion from the TPU core
//   busy, job_done        not-idle flag and one-cycle completion pulse
module tpu_loader #(
    parameter int unsigned SRAM_DATA_WIDTH = 32,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned SRAM_ADDR_WIDTH = 10,
    parameter int unsigned W_WORDS         = 64,
    parameter int unsigned D_WORDS         = 64
) (
    input  logic                       clk,
    input  logic                       srstn,
    input  logic                       load_start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       sram_wen_w,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_waddr_w,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wdata_w,
    output logic                       sram_wen_d,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_waddr_d,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wdata_d,
    output logic                       tpu_start,
    input  logic                       tpu_done,
    output logic                       busy,
    output logic                       job_done
);

    localparam int unsigned K    = SRAM_DATA_WIDTH / DATA_WIDTH;
    localparam int unsigned IdxW = (K > 1) ? $clog2(K) : 1;

    localparam logic [IdxW-1:0]            IdxLast = IdxW'(K - 1);
    localparam logic [SRAM_ADDR_WIDTH-1:0] WLast   = SRAM_ADDR_WIDTH'(W_WORDS - 1);
    localparam logic [SRAM_ADDR_WIDTH-1:0] DLast   = SRAM_ADDR_WIDTH'(D_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StLoadD,
        StStart,
        StWaitDone
    } state_e;

    state_e                     state_q, state_d;
    logic [IdxW-1:0]            idx_q, idx_d;       // element lane within current word
    logic [SRAM_DATA_WIDTH-1:0] pack_q, pack_d;     // partial word
    logic [SRAM_ADDR_WIDTH-1:0] cnt_q, cnt_d;       // words written in current phase
    logic                       fin_q, fin_d;       // final data word just written
    logic                       wen_w_q, wen_w_d;
    logic                       wen_d_q, wen_d_d;
    logic [SRAM_ADDR_WIDTH-1:0] waddr_w_q, waddr_w_d;
    logic [SRAM_ADDR_WIDTH-1:0] waddr_d_q, waddr_d_d;
    logic [SRAM_DATA_WIDTH-1:0] wdata_w_q, wdata_w_d;
    logic [SRAM_DATA_WIDTH-1:0] wdata_d_q, wdata_d_d;
    logic                       job_done_q, job_done_d;

    logic                       accept;
    logic                       word_done;
    logic [SRAM_DATA_WIDTH-1:0] word;

    // The cycle carrying the final data write already refuses input, so no
    // element past the job's quota is ever consumed.
    assign in_ready  = (state_q == StLoadW) || ((state_q == StLoadD) && !fin_q);
    assign accept    = in_valid && in_ready;
    assign word_done = accept && (idx_q == IdxLast);

    always_comb begin
        word = pack_q;
        word[idx_q * DATA_WIDTH +: DATA_WIDTH] = in_data;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pack_d     = pack_q;
        cnt_d      = cnt_q;
        fin_d      = 1'b0;
        wen_w_d    = 1'b0;
        wen_d_d    = 1'b0;
        waddr_w_d  = waddr_w_q;
        waddr_d_d  = waddr_d_q;
        wdata_w_d  = wdata_w_q;
        wdata_d_d  = wdata_d_q;
        job_done_d = 1'b0;

        if (accept) begin
            pack_d = word;
            idx_d  = word_done ? '0 : idx_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    state_d = StLoadW;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            StLoadW: begin
                if (word_done) begin
                    wen_w_d   = 1'b1;
                    waddr_w_d = cnt_q;
                    wdata_w_d = word;
                    if (cnt_q == WLast) begin
                        cnt_d   = '0;
                        state_d = StLoadD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StLoadD: begin
                if (fin_q) begin
                    state_d = StStart;
                end else if (word_done) begin
                    wen_d_d   = 1'b1;
                    waddr_d_d = cnt_q;
                    wdata_d_d = word;
                    if (cnt_q == DLast) begin
                        cnt_d = '0;
                        fin_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StStart: begin
                state_d = StWaitDone;
            end
            StWaitDone: begin
                if (tpu_done) begin
                    state_d    = StIdle;
                    job_done_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srstn) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            pack_q     <= '0;
            cnt_q      <= '0;
            fin_q      <= 1'b0;
            wen_w_q    <= 1'b0;
            wen_d_q    <= 1'b0;
            waddr_w_q  <= '0;
            waddr_d_q  <= '0;
            wdata_w_q  <= '0;
            wdata_d_q  <= '0;
            job_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pack_q     <= pack_d;
            cnt_q      <= cnt_d;
            fin_q      <= fin_d;
            wen_w_q    <= wen_w_d;
            wen_d_q    <= wen_d_d;
            waddr_w_q  <= waddr_w_d;
            waddr_d_q  <= waddr_d_d;
            wdata_w_q  <= wdata_w_d;
            wdata_d_q  <= wdata_d_d;
            job_done_q <= job_done_d;
        end
    end

    assign sram_wen_w   = wen_w_q;
    assign sram_waddr_w = waddr_w_q;
    assign sram_wdata_w = wdata_w_q;
    assign sram_wen_d   = wen_d_q;
    assign sram_waddr_d = waddr_d_q;
    assign sram_wdata_d = wdata_d_q;
    assign tpu_start    = (state_q == StStart);
    assign busy         = (state_q != StIdle);
    assign job_done     = job_done_q;

endmodule

// File: tb/tb_tpu_loader.sv
// Directed bench for tpu_loader with two weight words and two data words.
module tb_tpu_loader;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          srstn, load_start, in_valid, tpu_done;
    logic [7:0]    in_data;
    logic          in_ready, sram_wen_w, sram_wen_d, tpu_start, busy, job_done;
    logic [AW-1:0] sram_waddr_w, sram_waddr_d;
    logic [31:0]   sram_wdata_w, sram_wdata_d;

    always #5 clk = ~clk;

    tpu_loader #(
        .SRAM_DATA_WIDTH(32),
        .DATA_WIDTH     (8),
        .SRAM_ADDR_WIDTH(AW),
        .W_WORDS        (2),
        .D_WORDS        (2)
    ) dut (
        .clk         (clk),
        .srstn       (srstn),
        .load_start  (load_start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .sram_wen_w  (sram_wen_w),
        .sram_waddr_w(sram_waddr_w),
        .sram_wdata_w(sram_wdata_w),
        .sram_wen_d  (sram_wen_d),
        .sram_waddr_d(sram_waddr_d),
        .sram_wdata_d(sram_wdata_d),
        .tpu_start   (tpu_start),
        .tpu_done    (tpu_done),
        .busy        (busy),
        .job_done    (job_done)
    );

    int errors = 0;
    int checks = 0;

    // Observation log, filled just after each rising edge.
    int            nw = 0, nd = 0, nstart = 0, njd = 0, nacc = 0;
    int            cyc = 0, last_d_cyc = 0, start_cyc = 0;
    bit            both_seen = 1'b0;
    logic [AW-1:0] w_addr [8];
    logic [31:0]   w_data [8];
    logic [AW-1:0] d_addr [8];
    logic [31:0]   d_data [8];

    logic [31:0] exp_w [2];
    logic [31:0] exp_d [2];

    always @(posedge clk) begin
        if (in_valid && in_ready) nacc++;
        #1;
        cyc++;
        if (sram_wen_w) begin
            if (nw < 8) begin
                w_addr[nw] = sram_waddr_w;
                w_data[nw] = sram_wdata_w;
            end
            nw++;
        end
        if (sram_wen_d) begin
            if (nd < 8) begin
                d_addr[nd] = sram_waddr_d;
                d_data[nd] = sram_wdata_d;
            end
            nd++;
            last_d_cyc = cyc;
        end
        if (sram_wen_w && sram_wen_d) both_seen = 1'b1;
        if (tpu_start) begin
            nstart++;
            start_cyc = cyc;
        end
        if (job_done) njd++;
    end

    task automatic clear_log();
        nw = 0; nd = 0; nstart = 0; njd = 0; nacc = 0; both_seen = 1'b0;
    endtask

    task automatic start_job();
        @(negedge clk); load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
    endtask

    // Present one element and return on the negedge before the edge that takes it.
    task automatic push(input logic [7:0] v);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL push_timeout: in_ready stayed 0 for 50 cycles, want 1");
        end
    endtask

    task automatic stream(input int first, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            push(8'(first + i));
            if (gap) begin
                @(negedge clk); in_valid = 1'b0;
            end
        end
    endtask

    task automatic wait_start();
        int n = 0;
        while (nstart == 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (nstart == 0) begin
            errors++;
            $display("FAIL start_timeout: tpu_start never seen, want a pulse");
        end
    endtask

    // Call on the negedge of the START cycle or later, while in WAIT_DONE.
    task automatic finish_job();
        @(negedge clk); tpu_done = 1'b1;
        @(negedge clk); tpu_done = 1'b0;
        checks++;
        if (job_done !== 1'b1) begin
            errors++; $display("FAIL finish_job_done: got %b want 1", job_done);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL finish_busy: got %b want 0", busy);
        end
        @(negedge clk);
        checks++;
        if (job_done !== 1'b0) begin
            errors++; $display("FAIL finish_pulse_len: got %b want 0", job_done);
        end
    endtask

    task automatic test_reset();
        srstn = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = '0; tpu_done = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, sram_wen_w, sram_wen_d, tpu_start, busy, job_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {in_ready, sram_wen_w, sram_wen_d, tpu_start, busy, job_done});
        end
        checks++;
        if ({sram_waddr_w, sram_waddr_d, sram_wdata_w, sram_wdata_d} !== '0) begin
            errors++;
            $display("FAIL reset_bus: got %h %h %h %h want zeros",
                     sram_waddr_w, sram_waddr_d, sram_wdata_w, sram_wdata_d);
        end
        srstn = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        clear_log();
        start_job();
        stream(1, 16, 1'b0);
        @(negedge clk); in_data = 8'hFF;    // keep offering data past the quota
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_ready_after_16: got %b want 0", in_ready);
        end
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (nacc != 16) begin
            errors++; $display("FAIL b2b_accepted: got %0d want 16", nacc);
        end
        checks++;
        if (nw != 2 || nd != 2) begin
            errors++; $display("FAIL b2b_write_count: got w=%0d d=%0d want 2 2", nw, nd);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (w_addr[i] !== AW'(i) || w_data[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL b2b_wwrite%0d: got %0d/%h want %0d/%h",
                         i, w_addr[i], w_data[i], i, exp_w[i]);
            end
            checks++;
            if (d_addr[i] !== AW'(i) || d_data[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL b2b_dwrite%0d: got %0d/%h want %0d/%h",
                         i, d_addr[i], d_data[i], i, exp_d[i]);
            end
        end
        checks++;
        if (nstart != 1 || start_cyc != last_d_cyc + 1) begin
            errors++;
            $display("FAIL b2b_start: got n=%0d at %0d want 1 at %0d",
                     nstart, start_cyc, last_d_cyc + 1);
        end
        checks++;
        if (both_seen) begin
            errors++; $display("FAIL b2b_wen_overlap: got 1 want 0");
        end
        finish_job();
    endtask

    task automatic test_gapped();
        clear_log();
        start_job();
        stream(1, 15, 1'b1);
        push(8'h10);
        @(negedge clk); in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL gap_ready_after_16: got %b want 0", in_ready);
        end
        wait_start();
        checks++;
        if (nw != 2 || nd != 2) begin
            errors++; $display("FAIL gap_write_count: got w=%0d d=%0d want 2 2", nw, nd);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (w_addr[i] !== AW'(i) || w_data[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL gap_wwrite%0d: got %0d/%h want %0d/%h",
                         i, w_addr[i], w_data[i], i, exp_w[i]);
            end
            checks++;
            if (d_addr[i] !== AW'(i) || d_data[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL gap_dwrite%0d: got %0d/%h want %0d/%h",
                         i, d_addr[i], d_data[i], i, exp_d[i]);
            end
        end
        finish_job();
    endtask

    task automatic test_load_start_ignored();
        clear_log();
        start_job();
        stream(1, 10, 1'b0);
        load_start = 1'b1;                  // sampled in LOAD_D
        @(negedge clk); load_start = 1'b0; in_valid = 1'b0;
        stream(11, 6, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        wait_start();
        repeat (6) @(negedge clk);
        checks++;
        if (nw != 2 || nd != 2 || nstart != 1) begin
            errors++;
            $display("FAIL ls_counts: got w=%0d d=%0d start=%0d want 2 2 1", nw, nd, nstart);
        end
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ls_waiting: got busy=%b ready=%b want 1 0", busy, in_ready);
        end
        finish_job();
    endtask

    task automatic test_tpu_done_ignored();
        clear_log();
        start_job();
        stream(1, 2, 1'b0);
        tpu_done = 1'b1;                    // sampled in LOAD_W
        @(negedge clk); tpu_done = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || njd != 0) begin
            errors++;
            $display("FAIL td_early: got busy=%b ready=%b jd=%0d want 1 1 0",
                     busy, in_ready, njd);
        end
        stream(3, 14, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        wait_start();
        repeat (4) @(negedge clk);
        finish_job();
        checks++;
        if (njd != 1 || nw != 2 || nd != 2) begin
            errors++;
            $display("FAIL td_counts: got jd=%0d w=%0d d=%0d want 1 2 2", njd, nw, nd);
        end
    endtask

    task automatic test_reset_mid_job();
        clear_log();
        start_job();
        stream(1, 6, 1'b0);
        @(negedge clk); in_valid = 1'b0; srstn = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, sram_wen_w, sram_wen_d, tpu_start, busy, job_done} !== 6'b0) begin
            errors++;
            $display("FAIL rst_mid_ctrl: got %b want 000000",
                     {in_ready, sram_wen_w, sram_wen_d, tpu_start, busy, job_done});
        end
        checks++;
        if ({sram_waddr_w, sram_waddr_d, sram_wdata_w, sram_wdata_d} !== '0) begin
            errors++;
            $display("FAIL rst_mid_bus: got %h %h %h %h want zeros",
                     sram_waddr_w, sram_waddr_d, sram_wdata_w, sram_wdata_d);
        end
        srstn = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (nw != 1 || nd != 0 || nstart != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_quiet: got w=%0d d=%0d start=%0d busy=%b want 1 0 0 0",
                     nw, nd, nstart, busy);
        end
        clear_log();
        start_job();
        stream(1, 4, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        checks++;
        if (nw != 1 || w_addr[0] !== '0 || w_data[0] !== 32'h04030201) begin
            errors++;
            $display("FAIL rst_new_job: got n=%0d %0d/%h want 1 0/04030201",
                     nw, w_addr[0], w_data[0]);
        end
        stream(5, 12, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        wait_start();
        finish_job();
    endtask

    task automatic test_done_and_start();
        clear_log();
        start_job();
        stream(1, 16, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        wait_start();
        @(negedge clk); load_start = 1'b1; tpu_done = 1'b1;
        @(negedge clk); load_start = 1'b0; tpu_done = 1'b0;
        checks++;
        if (job_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL both_done: got jd=%b busy=%b want 1 0", job_done, busy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL both_stay_idle: got busy=%b ready=%b want 0 0", busy, in_ready);
        end
    endtask

    initial begin
        exp_w[0] = 32'h04030201; exp_w[1] = 32'h08070605;
        exp_d[0] = 32'h0C0B0A09; exp_d[1] = 32'h100F0E0D;
        test_reset();
        test_back_to_back();
        test_gapped();
        test_load_start_ignored();
        test_tpu_done_ignored();
        test_reset_mid_job();
        test_done_and_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tpu_loader.md
TPU_LOADER -- requirements
Module: tpu_loader

Interface
REQ-001 SHALL have parameter SRAM_DATA_WIDTH, default 32, meaning SRAM word width in bits; a multiple of DATA_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning width of one input stream element.
REQ-003 SHALL have parameter SRAM_ADDR_WIDTH, default 10, meaning SRAM address width.
REQ-004 SHALL have parameter W_WORDS, default 64, meaning number of words written to the weight SRAM per job; range 1..2^SRAM_ADDR_WIDTH.
REQ-005 SHALL have parameter D_WORDS, default 64, meaning number of words written to the data SRAM per job; same range.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 SHALL have port srstn, input, 1 bit: reset is synchronous and active-high, so srstn=1 at a rising edge of clk resets the block.
REQ-008 SHALL have port load_start, input, 1 bit: single-cycle job request.
REQ-009 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, DATA_WIDTH): host element stream.
REQ-010 SHALL have ports sram_wen_w (output, 1), sram_waddr_w (output, SRAM_ADDR_WIDTH) and sram_wdata_w (output, SRAM_DATA_WIDTH): weight SRAM write port.
REQ-011 SHALL have ports sram_wen_d (output, 1), sram_waddr_d (output, SRAM_ADDR_WIDTH) and sram_wdata_d (output, SRAM_DATA_WIDTH): data SRAM write port.
REQ-012 SHALL have port tpu_start, output, 1 bit: one-cycle start pulse to the TPU core.
REQ-013 SHALL have port tpu_done, input, 1 bit: completion from the TPU core.
REQ-014 SHALL have ports busy (output, 1) and job_done (output, 1): job_done is a one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, LOAD_W, LOAD_D, START, WAIT_DONE.
- IDLE->LOAD_W on load_start=1.
- LOAD_W->LOAD_D after write W_WORDS-1 issues.
- LOAD_D->START after write D_WORDS-1 issues.
- START->WAIT_DONE unconditionally after one cycle.
- WAIT_DONE->IDLE on tpu_done=1.
REQ-016 SHALL drive in_ready=1 only in LOAD_W and LOAD_D; an element is accepted when in_valid&in_ready.
REQ-017 SHALL pack K=SRAM_DATA_WIDTH/DATA_WIDTH accepted elements per word, little-endian: first element in bits [DATA_WIDTH-1:0].
REQ-018 SHALL assert the write enable of the current state's SRAM for exactly one cycle, in the cycle after the K-th element of a word is accepted, with registered address and data stable during that cycle.
REQ-019 SHALL start write addresses at 0 for each SRAM per job and increment by 1 per write; the last weight address is W_WORDS-1 and the last data address is D_WORDS-1; no wrap within a job.
REQ-020 SHALL never assert sram_wen_w and sram_wen_d in the same cycle; the final weight write may coincide with the first cycle of LOAD_D.
REQ-021 SHALL deassert in_ready in the cycle after the last element of the final data word is accepted; no element beyond W_WORDS*K + D_WORDS*K is consumed per job.
REQ-022 SHALL hold the packing position and partial word across in_valid=0 gaps of any length.
REQ-023 SHALL assert tpu_start=1 exactly in START, one cycle after the final data write.
REQ-024 SHALL hold busy=1 in every state except IDLE.
REQ-025 SHALL pulse job_done=1 for one cycle, in the cycle after tpu_done is sampled in WAIT_DONE.
REQ-026 SHALL ignore load_start outside IDLE, and ignore tpu_done outside WAIT_DONE.
REQ-027 SHALL, when load_start and tpu_done are both 1 in WAIT_DONE, return to IDLE and drop the load_start.

Reset
REQ-028 SHALL, while srstn=1 at a rising edge, enter IDLE and clear all outputs to 0: in_ready, write enables, addresses, write data, tpu_start, busy, job_done.
REQ-029 SHALL, on reset mid-job, discard any partial word, issue no further writes or tpu_start, and require a new load_start.

Verification
REQ-030 SHALL pass this case: W_WORDS=D_WORDS=2, elements 0x01..0x10 streamed back-to-back -> weight writes 0x04030201@0, 0x08070605@1; data writes 0x0C0B0A09@0, 0x100F0E0D@1; tpu_start one cycle after the last data write.
REQ-031 SHALL pass this case: in_valid toggled 1/0 every cycle through a job -> same SRAM contents as the back-to-back case, and in_ready low after element 16.
REQ-032 SHALL pass this case: load_start pulsed during LOAD_D -> no effect; exactly W_WORDS+D_WORDS writes and one tpu_start.
REQ-033 SHALL pass this case: tpu_done pulsed in LOAD_W, then again 5 cycles after tpu_start -> first ignored; job_done 1 cycle after the second; busy=0 next.
REQ-034 SHALL pass this case: srstn=1 after 6 elements of a job -> all outputs 0 next cycle; a new job then writes address 0 with elements 1..4 packed as 0x04030201.
